out_gain: RTL and testbench
===========================

OUT_GAIN -- requirements
Module: out_gain

Interface
REQ-001 SHALL have parameter SIG_BITS, default 16: sample width, input and output.
REQ-002 SHALL have parameter G_BITS, default 8: gain control width.
REQ-003 SHALL have parameter G_SHIFT, default 7: product right-shift; unity gain = 2^G_SHIFT = 128.
REQ-004 SHALL have port clk  input  1: single clock (clk_50 domain); everything synchronous to rising edge.
REQ-005 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port in  input  SIG_BITS: signed two's-complement sample from the delay stage.
REQ-007 SHALL have port in_valid  input  1: one-cycle strobe qualifying in.
REQ-008 SHALL have port gain  input  G_BITS: unsigned target gain from the analog-controls block.
REQ-009 SHALL have port mute  input  1: level; when high, target gain is 0.
REQ-010 SHALL have port out  output  SIG_BITS: offset-binary sample for the DAC SPI stage.
REQ-011 SHALL have port out_valid  output  1: one-cycle strobe qualifying out; drives the DAC "go".
REQ-012 SHALL have port clip  output  1: high with out_valid when the sample saturated.

Function
REQ-013 SHALL keep internal register gain_cur (G_BITS, unsigned); target = mute ? 0 : gain.
REQ-014 SHALL, on each cycle with in_valid=1, step gain_cur by +1 if below target, -1 if above, else hold; no steps without in_valid.
REQ-015 SHALL re-evaluate ramp direction every sample, so gain or mute changes mid-ramp reverse or stop cleanly with no overshoot.
REQ-016 SHALL apply to each sample the pre-step gain_cur captured in that sample's in_valid cycle.
REQ-017 SHALL run a 3-stage pipeline: S1 registers in and gain_cur; S2 registers the signed product in * {0,gain_cur} (SIG_BITS+G_BITS+1 = 25 bits); S3 computes, saturates, and registers out.
REQ-018 SHALL compute scaled = product >>> G_SHIFT (arithmetic; truncation toward minus infinity, no rounding).
REQ-019 SHALL saturate scaled to [-32768, 32767] and set clip=1 for that sample iff saturation occurred.
REQ-020 SHALL produce out = saturated value with MSB inverted (offset binary: -32768 -> 0x0000, 0 -> 0x8000, 32767 -> 0xFFFF).
REQ-021 SHALL assert out_valid exactly 3 cycles after the corresponding in_valid, for exactly one cycle.
REQ-022 SHALL hold out between strobes; out changes only in out_valid cycles.
REQ-023 SHALL accept in_valid on every cycle (fully pipelined, no stall, no back-pressure); sample order is preserved and no sample is dropped.
REQ-024 SHALL drive clip=0 whenever out_valid=0.

Reset
REQ-025 SHALL, while reset_n=0, immediately force out=0x8000 (midscale), out_valid=0, clip=0, gain_cur=0, and clear all pipeline valid bits.
REQ-026 SHALL discard any samples in flight when reset asserts mid-operation; no out_valid for them after release.
REQ-027 SHALL start from gain_cur=0 after reset and ramp up under REQ-014 (silent start, no click).

Verification
REQ-028 Ramp/unity: reset, gain=128, mute=0, 128 strobes of in=0 -> gain_cur=128; next in=0x1000 -> out=0x9000 three cycles later, clip=0.
REQ-029 Saturation: gain_cur=255; in=0x7FFF -> out=0xFFFF, clip=1; in=0x8000 -> out=0x0000, clip=1; in=0x0100 -> out=0x81FE, clip=0.
REQ-030 Mute: gain_cur=128, mute=1, 128 strobes -> gain_cur=0; any in thereafter -> out=0x8000; mute=0 -> gain_cur climbs by 1 per strobe back to 128.
REQ-031 Throughput: in_valid high for 10 consecutive cycles, in=1..10, gain_cur=128 -> 10 consecutive out_valid cycles starting 3 cycles later, out=0x8001..0x800A in order.
REQ-032 Truncation: gain_cur=1, in=-1 (0xFFFF) -> scaled=-1, out=0x7FFF; in=+1 -> out=0x8000.
REQ-033 Reset mid-stream: assert reset_n=0 one cycle after in_valid -> out=0x8000 and out_valid=0 immediately; no out_valid after release until a new in_valid.

Source files
------------

// File: rtl/out_gain.sv
// Output gain stage: ramped gain, scale by gain/2^G_SHIFT, saturate, offset-binary out with clip flag.
// Latency 3 cycles from in_valid to out_valid; accepts a sample every cycle, no back-pressure.
module out_gain #(
   parameter int SIG_BITS = 16,
   parameter int G_BITS   = 8,
   parameter int G_SHIFT  = 7
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [SIG_BITS-1:0] in,
   input  logic                in_valid,
   input  logic [G_BITS-1:0]   gain,
   input  logic                mute,
   output logic [SIG_BITS-1:0] out,
   output logic                out_valid,
   output logic                clip
);

   localparam int                  PROD_W = SIG_BITS + G_BITS + 1;
   localparam logic [G_BITS-1:0]   G_ONE  = G_BITS'(1);
   localparam logic [SIG_BITS-1:0] MID    = {1'b1, {(SIG_BITS-1){1'b0}}};

   logic [G_BITS-1:0]          r_gain_cur;
   logic [SIG_BITS-1:0]        r_s1_in;
   logic [G_BITS-1:0]          r_s1_gain;
   logic                       r_s1_vld;
   logic signed [PROD_W-1:0]   r_s2_prod;
   logic                       r_s2_vld;

   logic [G_BITS-1:0]          w_target;
   logic [PROD_W-1:0]          w_a;
   logic [PROD_W-1:0]          w_b;
   logic [PROD_W-1:0]          w_prod;
   logic signed [PROD_W-1:0]   w_scaled;
   logic [PROD_W-SIG_BITS:0]   w_hi;
   logic                       w_ovf;
   logic [SIG_BITS-1:0]        w_out_nxt;

   assign w_target = mute ? '0 : gain;

   // Low PROD_W bits of the product are the same for signed and unsigned
   // multiplication once both operands are extended to PROD_W.
   assign w_a    = {{(G_BITS+1){r_s1_in[SIG_BITS-1]}}, r_s1_in};
   assign w_b    = {{(SIG_BITS+1){1'b0}}, r_s1_gain};
   assign w_prod = w_a * w_b;

   assign w_scaled  = r_s2_prod >>> G_SHIFT;
   assign w_hi      = w_scaled[PROD_W-1:SIG_BITS-1];
   assign w_ovf     = !((&w_hi) || !(|w_hi));
   assign w_out_nxt = w_ovf ? (w_scaled[PROD_W-1] ? '0 : '1)
                            : {~w_scaled[SIG_BITS-1], w_scaled[SIG_BITS-2:0]};

   // Ramp direction is re-decided on every sample, so target changes never overshoot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gain_cur <= '0;
         r_s1_in    <= '0;
         r_s1_gain  <= '0;
         r_s1_vld   <= 1'b0;
      end else begin
         r_s1_vld <= in_valid;
         if (in_valid) begin
            r_s1_in   <= in;
            r_s1_gain <= r_gain_cur;
            if (r_gain_cur < w_target) begin
               r_gain_cur <= r_gain_cur + G_ONE;
            end else if (r_gain_cur > w_target) begin
               r_gain_cur <= r_gain_cur - G_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s2_prod <= '0;
         r_s2_vld  <= 1'b0;
      end else begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_prod <= w_prod;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out       <= MID;
         out_valid <= 1'b0;
         clip      <= 1'b0;
      end else begin
         out_valid <= r_s2_vld;
         clip      <= r_s2_vld & w_ovf;
         if (r_s2_vld) begin
            out <= w_out_nxt;
         end
      end
   end

endmodule

// File: tb/tb_out_gain.sv
// Randomized bench for out_gain: arithmetic reference model plus literal spot checks on key samples.
module tb_out_gain;

   localparam int MASK = 16383;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b0;
   logic [15:0] in_s      = '0;
   logic        in_valid  = 1'b0;
   logic [7:0]  gain_s    = '0;
   logic        mute      = 1'b0;
   logic [15:0] out_s;
   logic        out_valid_s;
   logic        clip_s;

   int          cyc        = 0;
   int          m_gain     = 0;
   int          compared   = 0;
   int          mismatched = 0;
   logic [15:0] last_out   = 16'h8000;

   bit          ev [0:MASK];
   logic [15:0] eo [0:MASK];
   bit          ec [0:MASK];
   bit          pv [0:MASK];
   logic [15:0] po [0:MASK];
   bit          pc [0:MASK];

   always #5 clk = ~clk;

   out_gain #(.SIG_BITS(16), .G_BITS(8), .G_SHIFT(7)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in        (in_s),
      .in_valid  (in_valid),
      .gain      (gain_s),
      .mute      (mute),
      .out       (out_s),
      .out_valid (out_valid_s),
      .clip      (clip_s)
   );

   // {clip, offset-binary out} for sample s scaled by g/128 with floor and saturation.
   function automatic logic [16:0] ref_calc(input logic [15:0] s, input int g);
      int p;
      p = int'($signed(s)) * g;
      p = p >>> 7;
      if (p > 32767)  return {1'b1, 16'hFFFF};
      if (p < -32768) return {1'b1, 16'h0000};
      return {1'b0, p[15:0] ^ 16'h8000};
   endfunction

   // Reference model: per accepted sample, schedule the expected output two edges later.
   always @(posedge clk) begin
      logic [16:0] r;
      int          t;
      int          d;
      cyc = cyc + 1;
      if (!reset_n) begin
         m_gain = 0;
         for (int i = 0; i < 4; i++) ev[(cyc + i) & MASK] = 1'b0;
      end else if (in_valid) begin
         r = ref_calc(in_s, m_gain);
         d = (cyc + 2) & MASK;
         ev[d] = 1'b1;
         eo[d] = r[15:0];
         ec[d] = r[16];
         t = mute ? 0 : int'(gain_s);
         if (m_gain < t) m_gain = m_gain + 1;
         else if (m_gain > t) m_gain = m_gain - 1;
      end
   end

   always @(negedge clk) begin
      int          i;
      bit          xv;
      bit          xc;
      logic [15:0] xo;
      i = cyc & MASK;
      if (!reset_n) begin
         xv = 1'b0; xc = 1'b0; xo = 16'h8000;
      end else begin
         xv = ev[i];
         xc = xv & ec[i];
         xo = xv ? eo[i] : last_out;
      end
      last_out = xo;
      compared = compared + 1;
      if (out_s !== xo || out_valid_s !== xv || clip_s !== xc) begin
         mismatched = mismatched + 1;
         $display("FAIL model cyc=%0d: got out=%h vld=%b clip=%b, want out=%h vld=%b clip=%b",
                  cyc, out_s, out_valid_s, clip_s, xo, xv, xc);
      end
      if (reset_n && pv[i]) begin
         compared = compared + 1;
         if (out_valid_s !== 1'b1 || out_s !== po[i] || clip_s !== pc[i]) begin
            mismatched = mismatched + 1;
            $display("FAIL literal cyc=%0d: got out=%h vld=%b clip=%b, want out=%h vld=1 clip=%b",
                     cyc, out_s, out_valid_s, clip_s, po[i], pc[i]);
         end
      end
   end

   task automatic step(input bit v, input logic [15:0] d);
      @(posedge clk);
      #2;
      in_valid = v;
      in_s     = d;
   endtask

   task automatic pin(input logic [15:0] d, input logic [15:0] e, input bit c);
      @(posedge clk);
      #2;
      in_valid = 1'b1;
      in_s     = d;
      pv[(cyc + 3) & MASK] = 1'b1;
      po[(cyc + 3) & MASK] = e;
      pc[(cyc + 3) & MASK] = c;
   endtask

   task automatic strobes(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 16'h0000);
   endtask

   initial begin
      repeat (3) step(1'b0, 16'h0000);
      reset_n = 1'b1;
      step(1'b0, 16'h0000);

      // Ramp to unity from the silent reset state.
      gain_s = 8'd128;
      strobes(128);
      pin(16'h1000, 16'h9000, 1'b0);

      // Back-to-back samples at unity gain.
      for (int k = 1; k <= 10; k++) pin(16'(k), 16'(16'h8000 + k), 1'b0);
      step(1'b0, 16'h0000);

      // Ramp down to gain 1: floor truncation of small values.
      gain_s = 8'd1;
      strobes(127);
      pin(16'hFFFF, 16'h7FFF, 1'b0);
      pin(16'h0001, 16'h8000, 1'b0);

      // Full gain saturation.
      gain_s = 8'd255;
      strobes(254);
      pin(16'h7FFF, 16'hFFFF, 1'b1);
      pin(16'h8000, 16'h0000, 1'b1);
      pin(16'h0100, 16'h81FE, 1'b0);

      // Mute ramps down to silence, unmute ramps back up.
      gain_s = 8'd128;
      strobes(127);
      mute = 1'b1;
      strobes(128);
      pin(16'h5A5A, 16'h8000, 1'b0);
      mute = 1'b0;
      strobes(128);
      pin(16'h1000, 16'h9000, 1'b0);
      step(1'b0, 16'h0000);

      // Random traffic with occasional gain and mute changes mid-ramp.
      for (int k = 0; k < 1500; k++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom));
         if ($urandom_range(0, 31) == 0) gain_s = 8'($urandom);
         if ($urandom_range(0, 63) == 0) mute = ~mute;
      end
      mute = 1'b0;
      repeat (5) step(1'b0, 16'h0000);

      // Reset one cycle after a sample: it must never emerge.
      step(1'b1, 16'h1234);
      step(1'b0, 16'h0000);
      reset_n = 1'b0;
      repeat (2) step(1'b0, 16'h0000);
      reset_n = 1'b1;
      repeat (8) step(1'b0, 16'h0000);

      // Gain restarts from zero after reset.
      gain_s = 8'd200;
      pin(16'h4000, 16'h8000, 1'b0);
      for (int k = 0; k < 300; k++) step(1'($urandom_range(0, 1)), 16'($urandom));
      repeat (6) step(1'b0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
